prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter AW, default 32, meaning Wishbone address and PC width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; DW SHALL be 16, 32 or 64.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; DEPTH SHALL be a power of two and at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 SHALL have ports as follows (clock and reset first):
- i_clk  in  1  clock; reset i_reset, synchronous, active-high; clock i_clk.
- i_reset  in  1  synchronous active-high reset.
- o_wb_addr  out  AW  byte address of the current fetch.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  DW/8  byte strobes.
- o_wb_we  out  1  write enable, tied 0.
- i_wb_dat  in  DW  read data.
- i_wb_ack  in  1  acknowledge.
- i_wb_err  in  1  bus error.
- i_redirect  in  1  flush the queue and restart at i_redirect_pc.
- i_redirect_pc  in  AW  new fetch address; bits below log2(DW/8) are ignored.
- o_valid  out  1  head entry valid.
- o_word  out  DW  head data.
- o_word_pc  out  AW  head address.
- o_error  out  1  head entry carries a bus error.
- i_ready  in  1  consumer accepts the head entry when o_valid=1.

Function
REQ-006 SHALL run an FSM with states IDLE, REQ, DRAIN and HALT.
REQ-007 IDLE->REQ SHALL occur when (count + 0) < DEPTH and not halted; it drives o_wb_cyc=1, o_wb_stb=all ones and o_wb_addr=fetch_pc.
REQ-008 In REQ with i_wb_ack, the block SHALL push {i_wb_dat, fetch_pc, err=0}, advance fetch_pc by DW/8 (wrapping modulo 2^AW) and go to IDLE.
REQ-009 In REQ with i_wb_err, the block SHALL push {0, fetch_pc, err=1} and go to HALT, where no further requests are issued.
REQ-010 At most one bus request SHALL be outstanding; o_wb_cyc and o_wb_stb SHALL stay asserted from issue until ack or err.
REQ-011 Queue SHALL be FIFO; a pop occurs on o_valid & i_ready; simultaneous push and pop SHALL leave the count unchanged.
REQ-012 Full queue (count=DEPTH) SHALL block new requests; empty queue SHALL deassert o_valid.
REQ-013 i_redirect SHALL take priority over all events:
- clear the queue the same cycle;
- set fetch_pc to the aligned i_redirect_pc;
- leave HALT.
REQ-014 i_redirect while a request is outstanding SHALL go to DRAIN:
- keep o_wb_cyc asserted until ack or err;
- discard that response;
- then go to IDLE.
REQ-015 A second i_redirect during DRAIN SHALL update fetch_pc and remain in DRAIN.
REQ-016 A pop coinciding with i_redirect SHALL be the only word delivered; no entry older than the redirect is visible afterwards.
REQ-017 Latency SHALL be: issue to ack cycle N gives o_valid at N+1 (register path).

Reset
REQ-018 On i_reset the block SHALL set:
- state to IDLE;
- fetch_pc to RESET_PC;
- queue to empty;
- o_wb_cyc, o_wb_stb, o_valid and o_error to 0;
- o_wb_addr to RESET_PC.
REQ-019 Reset during an outstanding cycle SHALL drop o_wb_cyc next cycle and ignore the late ack.

Configuration
REQ-020 Macro PREFETCH_BYPASS_EN defined: when the queue is empty and i_ready=1, an ack SHALL be forwarded combinationally (o_valid=1, o_word=i_wb_dat in the ack cycle) without a push.
REQ-021 PREFETCH_BYPASS_EN undefined: there SHALL be no combinational path from i_wb_* to o_valid/o_word, and latency SHALL be exactly per REQ-017.

Structure
REQ-022 A shared package SHALL hold the FSM state enum and the queue entry struct {data, pc, err}.
REQ-023 Queue storage SHALL be sub-module pq_fifo, parametrised by width and DEPTH, with count output.

Verification
REQ-024 Reset, zero-wait ack, i_ready=1 -> addresses 0,4,8,12; o_word_pc matches; each o_valid one cycle after its ack.
REQ-025 i_ready=0, DEPTH=4 -> exactly 4 requests, then o_wb_cyc=0 until the first pop.
REQ-026 Redirect to 0x100 while a request to 0x8 is outstanding, ack 3 cycles later -> that data is discarded; next o_wb_addr=0x100; o_valid=0 until the 0x100 data arrives.
REQ-027 i_wb_err at 0xC -> entry with o_error=1, pc=0xC; no further o_wb_cyc until redirect.
REQ-028 RESET_PC=0xFFFFFFFC -> second fetch address is 0x00000000.
REQ-029 Push and pop in the same cycle with count=2 -> count stays 2 and data order is preserved.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: FSM state encoding and queue entry layout.
// Entry fields are sized for the widest supported bus; instances use the low AW/DW bits.
package prefetch_queue_pkg;

  localparam int unsigned PqMaxAw = 64;
  localparam int unsigned PqMaxDw = 64;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrain,
    StHalt
  } pq_state_e;

  typedef struct packed {
    logic [PqMaxDw-1:0] data;
    logic [PqMaxAw-1:0] pc;
    logic               err;
  } pq_entry_t;

  function automatic pq_entry_t pq_make_entry(input logic [PqMaxDw-1:0] data,
                                              input logic [PqMaxAw-1:0] pc,
                                              input logic               err);
    pq_entry_t e;
    e.data = data;
    e.pc   = pc;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/pq_fifo.sv
// Power-of-two FIFO with occupancy count and a synchronous clear that overrides push/pop.
module pq_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/prefetch_queue.sv
// Wishbone instruction prefetcher feeding a FIFO of {data, pc, err} entries.
// Optional PREFETCH_BYPASS_EN forwards an ack straight to the consumer when the queue is empty.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic [AW-1:0]   o_wb_addr,
  output logic            o_wb_cyc,
  output logic [DW/8-1:0] o_wb_stb,
  output logic            o_wb_we,
  input  logic [DW-1:0]   i_wb_dat,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic            i_redirect,
  input  logic [AW-1:0]   i_redirect_pc,
  output logic            o_valid,
  output logic [DW-1:0]   o_word,
  output logic [AW-1:0]   o_word_pc,
  output logic            o_error,
  input  logic            i_ready
);

  localparam int unsigned StepB = DW / 8;
  localparam int unsigned OffW  = $clog2(StepB);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned EntW  = $bits(pq_entry_t);

  pq_state_e       state_q, state_d;
  logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   drain_pc_q, drain_pc_d;
  logic [AW-1:0]   redirect_pc;
  logic            push, pop, bypass, resp;
  logic            fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;
  logic [EntW-1:0] head_raw;
  pq_entry_t       push_entry, head;
  logic            unused_head;

  assign redirect_pc = {i_redirect_pc[AW-1:OffW], {OffW{1'b0}}};
  assign resp        = i_wb_ack | i_wb_err;
  assign head        = head_raw;
  assign unused_head = ^{head, fifo_count};

`ifdef PREFETCH_BYPASS_EN
  assign bypass = (state_q == StReq) & i_wb_ack & ~i_wb_err & ~i_redirect & fifo_empty & i_ready;
`else
  assign bypass = 1'b0;
`endif

  pq_fifo #(
    .Width(EntW),
    .Depth(DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .clear_i(i_redirect),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .rdata_o(head_raw),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign pop       = ~fifo_empty & i_ready;
  assign o_valid   = ~fifo_empty | bypass;
  assign o_word    = bypass ? i_wb_dat : head.data[DW-1:0];
  assign o_word_pc = bypass ? fetch_pc_q : head.pc[AW-1:0];
  assign o_error   = ~fifo_empty & head.err;
  assign o_wb_we   = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      drain_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drain_pc_q <= drain_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drain_pc_d = drain_pc_q;
    push       = 1'b0;
    push_entry = pq_make_entry(PqMaxDw'(i_wb_dat), PqMaxAw'(fetch_pc_q), 1'b0);
    if (i_redirect) begin
      // Any response arriving alongside a redirect belongs to the old stream.
      fetch_pc_d = redirect_pc;
      unique case (state_q)
        StReq: begin
          state_d    = resp ? StIdle : StDrain;
          drain_pc_d = fetch_pc_q;
        end
        StDrain: state_d = resp ? StIdle : StDrain;
        StIdle, StHalt: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: if (!fifo_full) state_d = StReq;
        StReq: begin
          if (i_wb_err) begin
            push       = 1'b1;
            push_entry = pq_make_entry('0, PqMaxAw'(fetch_pc_q), 1'b1);
            state_d    = StHalt;
          end else if (i_wb_ack) begin
            push       = ~bypass;
            fetch_pc_d = fetch_pc_q + AW'(StepB);
            state_d    = StIdle;
          end
        end
        StDrain: if (resp) state_d = StIdle;
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_addr = fetch_pc_q;
    case (state_q)
      StReq:   o_wb_cyc = 1'b1;
      StDrain: begin
        o_wb_cyc  = 1'b1;
        o_wb_addr = drain_pc_q;
      end
      default: o_wb_cyc = 1'b0;
    endcase
    o_wb_stb = {(DW / 8){o_wb_cyc}};
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a zero-wait Wishbone slave plus per-feature test tasks.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_addr, wb_addr2, wb_dat, redirect_pc;
  logic        wb_cyc, wb_cyc2, wb_we, wb_we2, wb_ack, wb_err, redirect, ready;
  logic [3:0]  wb_stb, wb_stb2;
  logic        valid, valid2, error, error2;
  logic [31:0] word, word2, word_pc, word_pc2;

  logic        auto_en, auto_ack, auto_err, err_en, man_ack, man_err;
  logic [31:0] auto_dat, man_dat, err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign wb_ack = auto_ack | man_ack;
  assign wb_err = auto_err | man_err;
  assign wb_dat = man_ack ? man_dat : auto_dat;

  prefetch_queue dut (
    .i_clk(clk), .i_reset(rst),
    .o_wb_addr(wb_addr), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .i_wb_dat(wb_dat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_valid(valid), .o_word(word), .o_word_pc(word_pc), .o_error(error), .i_ready(ready)
  );

  // Same stimulus, different start address, to exercise PC wrap.
  prefetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_reset(rst),
    .o_wb_addr(wb_addr2), .o_wb_cyc(wb_cyc2), .o_wb_stb(wb_stb2), .o_wb_we(wb_we2),
    .i_wb_dat(wb_dat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_valid(valid2), .o_word(word2), .o_word_pc(word_pc2), .o_error(error2), .i_ready(ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Zero-wait slave: answers in the same cycle the request is seen.
  always @(negedge clk) begin
    auto_ack = 1'b0;
    auto_err = 1'b0;
    if (auto_en && wb_cyc) begin
      if (err_en && wb_addr == err_addr) auto_err = 1'b1;
      else auto_ack = 1'b1;
    end
    auto_dat = mem_word(wb_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    auto_en = 0; err_en = 0; man_ack = 0; man_err = 0; man_dat = '0;
    ready = 0; redirect = 0; redirect_pc = '0; err_addr = '0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic wait_req(input logic [31:0] addr, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (wb_cyc && wb_addr == addr) found = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({wb_cyc, wb_stb, valid, error, wb_we} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cyc/stb/valid/err/we=%b required 0", {wb_cyc, wb_stb, valid, error, wb_we});
    end
    n_tests++;
    if (wb_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h required 00000000", wb_addr);
    end
    n_tests++;
    if (wb_addr2 !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL reset_addr_wrap: got %h required fffffffc", wb_addr2);
    end
  endtask

  task automatic test_stream();
    bit found;
    do_reset();
    ready = 1; auto_en = 1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'(4 * k);
      wait_req(a, 5, found);
      n_tests++;
      if (!found || wb_stb !== 4'hF || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_req%0d: got found=%0d addr=%h stb=%h valid=%b required addr=%h stb=f valid=0",
                 k, found, wb_addr, wb_stb, valid, a);
      end
      if (k < 2) begin
        n_tests++;
        if (wb_addr2 !== (k == 0 ? 32'hFFFF_FFFC : 32'h0)) begin
          n_fail++;
          $display("FAIL wrap_addr%0d: got %h", k, wb_addr2);
        end
      end
      step();
      n_tests++;
      if (valid !== 1'b1 || word !== mem_word(a) || word_pc !== a || error !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_data%0d: got v=%b word=%h pc=%h err=%b required v=1 word=%h pc=%h err=0",
                 k, valid, word, word_pc, error, mem_word(a), a);
      end
    end
  endtask

  task automatic test_full();
    int n_req = 0;
    do_reset();
    auto_en = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wb_cyc) n_req++;
    end
    n_tests++;
    if (n_req !== 4 || wb_cyc !== 1'b0 || valid !== 1'b1 || word_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL full_block: got reqs=%0d cyc=%b valid=%b pc=%h required reqs=4 cyc=0 valid=1 pc=0",
               n_req, wb_cyc, valid, word_pc);
    end
    ready = 1;
    step();
    ready = 0;
    n_tests++;
    if (wb_cyc !== 1'b0 || word_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL full_pop: got cyc=%b pc=%h required cyc=0 pc=4", wb_cyc, word_pc);
    end
    step();
    n_tests++;
    if (wb_cyc !== 1'b1 || wb_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL full_resume: got cyc=%b addr=%h required cyc=1 addr=10", wb_cyc, wb_addr);
    end
  endtask

  task automatic test_push_pop();
    bit found;
    do_reset();
    auto_en = 1;
    wait_req(32'h8, 10, found);
    n_tests++;
    if (!found || dut.u_fifo.count_o !== 3'd2 || word_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL pp_setup: got found=%0d count=%0d pc=%h required count=2 pc=0",
               found, dut.u_fifo.count_o, word_pc);
    end
    ready = 1;
    step();
    n_tests++;
    if (dut.u_fifo.count_o !== 3'd2 || word_pc !== 32'h4 || word !== mem_word(32'h4)) begin
      n_fail++;
      $display("FAIL pp_same_cycle: got count=%0d pc=%h word=%h required count=2 pc=4 word=%h",
               dut.u_fifo.count_o, word_pc, word, mem_word(32'h4));
    end
    step();
    ready = 0;
    n_tests++;
    if (dut.u_fifo.count_o !== 3'd1 || word_pc !== 32'h8 || word !== mem_word(32'h8)) begin
      n_fail++;
      $display("FAIL pp_order: got count=%0d pc=%h word=%h required count=1 pc=8 word=%h",
               dut.u_fifo.count_o, word_pc, word, mem_word(32'h8));
    end
  endtask

  task automatic test_redirect_drain();
    bit found;
    do_reset();
    auto_en = 1; ready = 1;
    wait_req(32'h8, 10, found);
    auto_en = 0;
    redirect = 1; redirect_pc = 32'h102;
    step();
    redirect = 0;
    n_tests++;
    if (!found || wb_cyc !== 1'b1 || wb_addr !== 32'h8 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hold: got found=%0d cyc=%b addr=%h valid=%b required cyc=1 addr=8 valid=0",
               found, wb_cyc, wb_addr, valid);
    end
    step();
    step();
    man_ack = 1; man_dat = 32'hDEAD_BEEF;
    step();
    man_ack = 0;
    n_tests++;
    if (wb_cyc !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_discard: got cyc=%b valid=%b required cyc=0 valid=0", wb_cyc, valid);
    end
    step();
    n_tests++;
    if (wb_cyc !== 1'b1 || wb_addr !== 32'h100 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_restart: got cyc=%b addr=%h valid=%b required cyc=1 addr=100 valid=0",
               wb_cyc, wb_addr, valid);
    end
    auto_en = 1;
    step();
    n_tests++;
    if (valid !== 1'b1 || word_pc !== 32'h100 || word !== mem_word(32'h100)) begin
      n_fail++;
      $display("FAIL drain_newdata: got v=%b pc=%h word=%h required v=1 pc=100 word=%h",
               valid, word_pc, word, mem_word(32'h100));
    end
  endtask

  task automatic test_error();
    int n_req = 0;
    int n_late = 0;
    do_reset();
    auto_en = 1; err_en = 1; err_addr = 32'hC;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wb_cyc) n_req++;
    end
    ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb_cyc) n_late++;
    end
    ready = 0;
    n_tests++;
    if (valid !== 1'b1 || error !== 1'b1 || word_pc !== 32'hC || word !== 32'h0) begin
      n_fail++;
      $display("FAIL err_entry: got v=%b err=%b pc=%h word=%h required v=1 err=1 pc=c word=0",
               valid, error, word_pc, word);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (wb_cyc) n_late++;
    end
    n_tests++;
    if (n_req !== 4 || n_late !== 0) begin
      n_fail++;
      $display("FAIL err_halt: got reqs=%0d after_halt=%0d required 4 and 0", n_req, n_late);
    end
    auto_en = 0; err_en = 0;
    redirect = 1; redirect_pc = 32'h40;
    step();
    redirect = 0;
    n_tests++;
    if (valid !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_flush: got v=%b err=%b required 0 0", valid, error);
    end
    step();
    n_tests++;
    if (wb_cyc !== 1'b1 || wb_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL err_redirect: got cyc=%b addr=%h required cyc=1 addr=40", wb_cyc, wb_addr);
    end
  endtask

  task automatic test_reset_outstanding();
    bit found;
    do_reset();
    wait_req(32'h0, 5, found);
    rst = 1;
    step();
    rst = 0;
    n_tests++;
    if (!found || wb_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drop: got found=%0d cyc=%b required cyc=0", found, wb_cyc);
    end
    man_ack = 1; man_dat = 32'h1234_5678;
    step();
    man_ack = 0;
    n_tests++;
    if (valid !== 1'b0 || wb_cyc !== 1'b1 || wb_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_late_ack: got v=%b cyc=%b addr=%h required v=0 cyc=1 addr=0",
               valid, wb_cyc, wb_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_push_pop();
    test_redirect_drain();
    test_error();
    test_reset_outstanding();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
